// File: rtl/bcd_counter_display_pkg.sv
// Shared constants for the BCD counter display: active-low 7-segment codes (gfedcba)
// and digit helpers.
package bcd_counter_display_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Switch inputs can present 10..15; those saturate to 9 rather than wrap.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_counter_display_seg7_dec.sv
// Combinational BCD -> active-low 7-segment decoder with a blank override.
module bcd_seg7_dec
  import bcd_counter_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_digit)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter on a prescaled tick, with parallel load, wrap pulse
// and registered 7-segment outputs with optional leading-zero blanking.
module bcd_counter_display
  import bcd_counter_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50_000_000
)(
  input  logic                    CLOCK_50,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic                    UP_DN,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] LOAD_VAL,
  input  logic                    BLANK_LZ,
  output logic [4*NUM_DIGITS-1:0] BCD,
  output logic                    CARRY,
  output logic [7*NUM_DIGITS-1:0] HEX
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0]           r_presc;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic                    r_carry;
  logic [7*NUM_DIGITS-1:0] r_hex;

  logic                    w_tick;
  logic                    w_wrap;
  logic [4*NUM_DIGITS-1:0] w_bcd_next;
  logic [4*NUM_DIGITS-1:0] w_load_clamped;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [7*NUM_DIGITS-1:0] w_seg;

  assign w_tick = EN && (r_presc == PW'(TICK_DIV - 1));

  // Ripple increment/decrement; the chain runs out of the top digit only on wrap.
  always_comb begin
    logic w_ripple;
    w_ripple   = 1'b1;
    w_bcd_next = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_ripple) begin
        if (UP_DN) begin
          if (r_bcd[4*i +: 4] == BCD_MAX) begin
            w_bcd_next[4*i +: 4] = 4'd0;
          end else begin
            w_bcd_next[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
            w_ripple = 1'b0;
          end
        end else begin
          if (r_bcd[4*i +: 4] == 4'd0) begin
            w_bcd_next[4*i +: 4] = BCD_MAX;
          end else begin
            w_bcd_next[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
            w_ripple = 1'b0;
          end
        end
      end
    end
    w_wrap = w_ripple;
  end

  // A digit blanks only when it and every digit above it are zero.
  always_comb begin
    logic w_all_zero;
    w_all_zero = 1'b1;
    w_blank    = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_all_zero = w_all_zero && (r_bcd[4*i +: 4] == 4'd0);
      w_blank[i] = BLANK_LZ && w_all_zero;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_load_clamped[4*gi +: 4] = bcd_clamp(LOAD_VAL[4*gi +: 4]);

      bcd_seg7_dec u_dec (
        .i_digit (r_bcd[4*gi +: 4]),
        .i_blank (w_blank[gi]),
        .o_seg   (w_seg[7*gi +: 7])
      );
    end
  endgenerate

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_presc <= '0;
      r_bcd   <= '0;
      r_carry <= 1'b0;
      r_hex   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      r_hex   <= w_seg;
      r_carry <= 1'b0;
      if (LOAD) begin
        r_presc <= '0;
        r_bcd   <= w_load_clamped;
      end else begin
        if (EN) begin
          r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
        if (w_tick) begin
          r_bcd   <= w_bcd_next;
          r_carry <= w_wrap;
        end
      end
    end
  end

  assign BCD   = r_bcd;
  assign CARRY = r_carry;
  assign HEX   = r_hex;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Scoreboard bench for bcd_counter_display (2 digits, tick every 4 clocks).
module tb_bcd_counter_display;

  logic        CLOCK_50 = 1'b0;
  logic        RST_N    = 1'b0;
  logic        EN       = 1'b0;
  logic        UP_DN    = 1'b1;
  logic        LOAD     = 1'b0;
  logic [7:0]  LOAD_VAL = 8'h00;
  logic        BLANK_LZ = 1'b1;
  logic [7:0]  BCD;
  logic        CARRY;
  logic [13:0] HEX;

  typedef struct {
    int          cyc;
    string       name;
    logic [7:0]  bcd;
    logic        carry;
    logic [13:0] hex;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;
  event async_ev;

  bcd_counter_display #(
    .NUM_DIGITS (2),
    .TICK_DIV   (4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .EN       (EN),
    .UP_DN    (UP_DN),
    .LOAD     (LOAD),
    .LOAD_VAL (LOAD_VAL),
    .BLANK_LZ (BLANK_LZ),
    .BCD      (BCD),
    .CARRY    (CARRY),
    .HEX      (HEX)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic push(input int dc, input string nm, input logic [7:0] b,
                      input logic c, input logic [13:0] h);
    exp_t e;
    e.cyc   = cyc + dc;
    e.name  = nm;
    e.bcd   = b;
    e.carry = c;
    e.hex   = h;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic check_due();
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_vec++;
      if (e.cyc < cyc) begin
        n_err++;
        $display("FAIL %s: vector due at cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      end else if (BCD !== e.bcd || CARRY !== e.carry || HEX !== e.hex) begin
        n_err++;
        $display("FAIL %s: cycle %0d got BCD=%h CARRY=%b HEX=%h, expected BCD=%h CARRY=%b HEX=%h",
                 e.name, cyc, BCD, CARRY, HEX, e.bcd, e.carry, e.hex);
      end else begin
        $display("ok   %s: cycle %0d BCD=%h CARRY=%b HEX=%h", e.name, cyc, BCD, CARRY, HEX);
      end
    end
  endtask

  // Monitor: samples on the falling edge, or immediately for the async-reset check.
  initial begin
    forever begin
      @(negedge CLOCK_50 or async_ev);
      check_due();
    end
  end

  initial begin
    step(2);
    push(1, "reset_hold", 8'h00, 1'b0, {7'h7F, 7'h7F});
    step(1);
    RST_N = 1'b1;
    push(1, "release_blank", 8'h00, 1'b0, {7'h7F, 7'h40});
    step(1);

    EN = 1'b1; UP_DN = 1'b1;
    push(3,  "up_pre",   8'h00, 1'b0, {7'h7F, 7'h40});
    push(4,  "up_first", 8'h01, 1'b0, {7'h7F, 7'h40});
    push(5,  "hex_01",   8'h01, 1'b0, {7'h7F, 7'h79});
    push(36, "up_09",    8'h09, 1'b0, {7'h7F, 7'h00});
    push(40, "up_10",    8'h10, 1'b0, {7'h7F, 7'h10});
    push(41, "hex_10",   8'h10, 1'b0, {7'h79, 7'h40});
    step(41);

    LOAD = 1'b1; LOAD_VAL = 8'h99;
    push(1, "load_99", 8'h99, 1'b0, {7'h79, 7'h40});
    step(1);
    LOAD = 1'b0;
    push(1, "hex_99",         8'h99, 1'b0, {7'h10, 7'h10});
    push(3, "load_presc_clr", 8'h99, 1'b0, {7'h10, 7'h10});
    push(4, "wrap_up",        8'h00, 1'b1, {7'h10, 7'h10});
    push(5, "carry_1cyc",     8'h00, 1'b0, {7'h7F, 7'h40});
    step(5);

    UP_DN = 1'b0;
    push(2, "down_pre",    8'h00, 1'b0, {7'h7F, 7'h40});
    push(3, "wrap_down",   8'h99, 1'b1, {7'h7F, 7'h40});
    push(4, "borrow_1cyc", 8'h99, 1'b0, {7'h10, 7'h10});
    push(7, "down_98",     8'h98, 1'b0, {7'h10, 7'h10});
    push(8, "hex_98",      8'h98, 1'b0, {7'h10, 7'h00});
    step(8);

    // Prescaler now sits at 1; two more edges put the load on a tick cycle.
    step(2);
    LOAD = 1'b1; LOAD_VAL = 8'h3C;
    push(1, "load_clamp_tick", 8'h39, 1'b0, {7'h10, 7'h00});
    step(1);
    LOAD = 1'b0;
    push(1, "hex_39",          8'h39, 1'b0, {7'h30, 7'h10});
    push(3, "no_tick_yet",     8'h39, 1'b0, {7'h30, 7'h10});
    push(4, "tick_after_load", 8'h38, 1'b0, {7'h30, 7'h10});
    step(4);

    UP_DN = 1'b1;
    step(2);
    #3;
    RST_N = 1'b0;
    #1;
    push(0, "async_reset", 8'h00, 1'b0, {7'h7F, 7'h7F});
    -> async_ev;
    step(1);
    RST_N = 1'b1;
    push(1, "restart_hex", 8'h00, 1'b0, {7'h7F, 7'h40});
    push(3, "restart_pre", 8'h00, 1'b0, {7'h7F, 7'h40});
    push(4, "restart_01",  8'h01, 1'b0, {7'h7F, 7'h40});
    push(5, "hex_01b",     8'h01, 1'b0, {7'h7F, 7'h79});
    step(5);
    BLANK_LZ = 1'b0;
    push(1, "no_blank", 8'h01, 1'b0, {7'h40, 7'h79});
    step(1);
    EN = 1'b0;
    push(6, "en_hold", 8'h01, 1'b0, {7'h40, 7'h79});
    step(6);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) step(1);
    while (sb_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: vector never checked (due cycle %0d, now %0d)", sb_q[0].name, sb_q[0].cyc, cyc);
      void'(sb_q.pop_front());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
